// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite word memory slave with configurable wait states,
// byte-lane writes and two-cycle ERROR responses for bad address phases.
module ahb_mem_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hwstrb,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);
    localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, DATA = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4;
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
    logic [2:0] state, next, launch;
    logic [1:0] wcnt;
    logic [AW+1:0] a_addr;
    logic a_write;
    logic [2:0] a_size;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic accept, bad;
    logic [3:0] lanes, be;
    logic [AW-1:0] widx;
    logic unused;
    assign unused = ^{hburst, htrans[0]};
    assign hreadyout = state != WAIT && state != ERR1;
    assign hresp = state == ERR1 || state == ERR2;
    // Only sample a new address phase while our own data phase is not stalling.
    assign accept = hsel && hready && htrans[1] && hreadyout;
    assign bad = {1'b0, haddr} >= LIMIT || hsize > 3'd2 || (hsize == 3'd1 && haddr[0])
                 || (hsize == 3'd2 && haddr[1:0] != 2'b00);
    assign launch = bad ? ERR1 : (WAIT_CYCLES > 0 ? WAIT : DATA);
    assign next = state == WAIT ? (wcnt == 2'd0 ? DATA : WAIT) : state == ERR1 ? ERR2 : accept ? launch : IDLE;
    assign widx = a_addr[AW+1:2];
    assign lanes = a_size == 3'd0 ? 4'b0001 << a_addr[1:0] : a_size == 3'd1 ? 4'b0011 << a_addr[1:0] : 4'b1111;
    assign be = lanes & hwstrb;
    assign hrdata = (state == WAIT || state == DATA) ? mem[widx] : '0;
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= IDLE;
            wcnt <= 2'd0;
        end else begin
            state <= next;
            wcnt <= (accept && !bad) ? 2'(WAIT_CYCLES - 1) : (state == WAIT && wcnt != 2'd0) ? wcnt - 2'd1 : wcnt;
        end
        if (!hreset && accept) begin
            a_addr <= haddr[AW+1:0];
            a_write <= hwrite;
            a_size <= hsize;
        end
    end
    // DATA is only ever reached by valid transfers, so this never commits errored writes.
    always_ff @(posedge hclk) begin
        if (!hreset && state == DATA && a_write)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: directed checks of three slaves (0, 2 and 3 wait states)
// sharing one bus; hready follows whichever slave owns the current transfer.
module tb_ahb_mem_slave;
    logic hclk = 0, hreset = 1;
    always #5 hclk = ~hclk;
    logic [2:0] sel = 0, hsize = 0, hburst = 0;
    logic [15:0] haddr = 0;
    logic [1:0] htrans = 0, cur = 0;
    logic hwrite = 0, hready;
    logic [3:0] hwstrb = 0;
    logic [31:0] hwdata = 0, rd;
    logic [2:0] ro, rs;
    logic [2:0][31:0] rdt;
    logic r0, r1;
    int total = 0, fails = 0, n;
    assign hready = ro[cur];

    ahb_mem_slave #(.WAIT_CYCLES(0)) u0 (.hclk(hclk), .hreset(hreset), .hsel(sel[0]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro[0]), .hresp(rs[0]), .hrdata(rdt[0]));
    ahb_mem_slave #(.WAIT_CYCLES(2)) u2 (.hclk(hclk), .hreset(hreset), .hsel(sel[1]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro[1]), .hresp(rs[1]), .hrdata(rdt[1]));
    ahb_mem_slave #(.WAIT_CYCLES(3)) u3 (.hclk(hclk), .hreset(hreset), .hsel(sel[2]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro[2]), .hresp(rs[2]), .hrdata(rdt[2]));

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic xfer(input logic [1:0] d, input logic w, input logic [15:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] st);
        cur = d; sel = 3'b001 << d; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz; hburst = 3'd1;
        @(posedge hclk); #1;
        sel = 0; htrans = 0; hwrite = 0; hwdata = wd; hwstrb = st;
        r0 = rs[d]; n = 0;
        while (!hready && n < 20) begin
            @(posedge hclk); #1;
            n++;
        end
        rd = rdt[d]; r1 = rs[d];
        @(posedge hclk); #1;
    endtask

    initial begin
        repeat (2) @(posedge hclk);
        #1 hreset = 0;
        chk("rst hreadyout", ro[0], 1); chk("rst hresp", rs[0], 0); chk("rst hrdata", rdt[0], 0);
        xfer(0, 1, 16'h10, 2, 32'hDEADBEEF, 4'hF); chk("w0 stalls", n, 0); chk("w0 resp", r1, 0);
        xfer(0, 0, 16'h10, 2, 0, 0); chk("r0 data", rd, 32'hDEADBEEF); chk("r0 stalls", n, 0); chk("r0 resp", r1, 0);
        xfer(0, 1, 16'h10, 2, 32'h11223344, 4'hF);
        xfer(0, 1, 16'h13, 0, 32'hAA000000, 4'hF);
        xfer(0, 0, 16'h10, 2, 0, 0); chk("byte write", rd, 32'hAA223344);
        xfer(0, 1, 16'h12, 1, 32'h55660000, 4'b0100);
        xfer(0, 0, 16'h10, 2, 0, 0); chk("half strobed", rd, 32'hAA663344);
        xfer(0, 1, 16'h00, 2, 32'hCAFEF00D, 4'hF);
        xfer(0, 1, 16'h100, 2, 32'h0BADF00D, 4'hF);
        chk("oor stalls", n, 1); chk("oor resp1", r0, 1); chk("oor resp2", r1, 1); chk("oor rdata", rd, 0);
        xfer(0, 0, 16'h00, 2, 0, 0); chk("oor no write", rd, 32'hCAFEF00D); chk("post err resp", r1, 0);
        xfer(0, 1, 16'h02, 2, 32'h0BAD0BAD, 4'hF);
        chk("mis stalls", n, 1); chk("mis resp1", r0, 1); chk("mis resp2", r1, 1);
        xfer(0, 0, 16'h00, 2, 0, 0); chk("mis no write", rd, 32'hCAFEF00D);
        xfer(0, 0, 16'h04, 3, 0, 0); chk("size3 resp", r1, 1); chk("size3 stalls", n, 1);
        cur = 0; sel = 3'b001; haddr = 16'h20; htrans = 2'b10; hwrite = 1; hsize = 2;
        @(posedge hclk); #1;
        htrans = 2'b11; hwrite = 0; hwdata = 32'h12345678; hwstrb = 4'hF;
        chk("b2b wr ready", ro[0], 1);
        @(posedge hclk); #1;
        sel = 0; htrans = 0;
        chk("b2b rd data", rdt[0], 32'h12345678); chk("b2b rd ready", ro[0], 1); chk("b2b rd resp", rs[0], 0);
        @(posedge hclk); #1;
        xfer(1, 1, 16'h10, 2, 32'hDEADBEEF, 4'hF); chk("w2 stalls", n, 2);
        xfer(1, 0, 16'h10, 2, 0, 0); chk("r2 stalls", n, 2); chk("r2 data", rd, 32'hDEADBEEF); chk("r2 resp", r1, 0);
        xfer(2, 1, 16'h10, 2, 32'h01020304, 4'hF); chk("w3 stalls", n, 3);
        cur = 2; sel = 3'b100; haddr = 16'h10; htrans = 2'b10; hwrite = 0; hsize = 2;
        @(posedge hclk); #1;
        sel = 0; htrans = 0;
        chk("w3 wait1 ready", ro[2], 0); chk("w3 wait1 data", rdt[2], 32'h01020304);
        @(posedge hclk); #1;
        hreset = 1;
        @(posedge hclk); #1;
        hreset = 0;
        chk("midrst ready", ro[2], 1); chk("midrst resp", rs[2], 0); chk("midrst rdata", rdt[2], 0);
        xfer(2, 1, 16'h14, 2, 32'h55AA55AA, 4'hF); chk("w3b stalls", n, 3);
        xfer(2, 0, 16'h14, 2, 0, 0); chk("r3b stalls", n, 3); chk("r3b data", rd, 32'h55AA55AA);
        xfer(0, 0, 16'h10, 2, 0, 0); chk("mem kept", rd, 32'hAA663344);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 16, haddr width; DATA_WIDTH, 32, bus width (fixed 32); MEM_DEPTH, 64, number of 32-bit words; WAIT_CYCLES, 0, wait states per OKAY transfer (0..3).
REQ-002 SHALL have ports (name direction width meaning):
- hclk in 1: clock; one clock domain, all logic on rising edge.
- hreset in 1: synchronous, active-high reset.
- hsel in 1: slave select.
- haddr in ADDR_WIDTH: byte address.
- htrans in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite in 1: 1 = write.
- hsize in 3: 0 = byte, 1 = half, 2 = word.
- hburst in 3: burst type; informational only.
- hwstrb in 4: write byte strobes; valid in the data phase.
- hwdata in 32: write data; valid in the data phase.
- hready in 1: bus ready (hreadyin).
- hreadyout out 1: slave ready.
- hresp out 1: 0 = OKAY, 1 = ERROR.
- hrdata out 32: read data.

Function
REQ-003 Address phase SHALL be accepted on a rising edge when hsel=1, hready=1 and htrans[1]=1; it captures haddr, hwrite and hsize.
REQ-004 When hsel=0, or htrans is IDLE or BUSY, with hready=1: no access; the next cycle SHALL give hreadyout=1, hresp=0.
REQ-005 The address phase SHALL be flagged as an error when any of these holds:
- haddr >= MEM_DEPTH*4;
- hsize > 2;
- misaligned: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0.
REQ-006 The FSM SHALL have these states:
- IDLE: no data phase pending.
- WAIT: wait states in progress.
- DATA: final data cycle.
- ERR1: first error cycle.
- ERR2: second error cycle.
REQ-007 FSM transitions:
- Accepted valid transfer: to WAIT if WAIT_CYCLES>0, else to DATA.
- Accepted error transfer: to ERR1.
REQ-008 WAIT SHALL assert hreadyout=0, hresp=0 for exactly WAIT_CYCLES cycles (2-bit counter loaded with WAIT_CYCLES-1, decremented), then move to DATA.
REQ-009 DATA SHALL assert hreadyout=1, hresp=0.
- A new accepted address phase in the same cycle gives a pipelined back-to-back transfer.
- Otherwise return to IDLE.
REQ-010 ERR1 SHALL drive hreadyout=0, hresp=1; ERR2 SHALL drive hreadyout=1, hresp=1.
REQ-011 Error handling:
- No memory write for an errored transfer.
- hrdata=0 during ERR1/ERR2.
- A new address phase accepted in ERR2 SHALL be processed normally.
REQ-012 Write lane mask SHALL be derived from hsize and haddr[1:0]:
- byte: 1 << a[1:0];
- half: 4'b0011 << a[1:0];
- word: 4'b1111.
REQ-013 Effective byte enable SHALL be lane mask AND hwstrb.
REQ-014 A write SHALL commit to mem[addr[ADDR_WIDTH-1:2]] on the edge ending DATA (hreadyout=1), updating only enabled byte lanes.
REQ-015 Read: in WAIT and DATA, hrdata SHALL equal the full 32-bit word mem[captured addr>>2]; in all other states hrdata=0.
REQ-016 Read-after-write to the same word on back-to-back transfers SHALL return the newly written data; this follows from the commit edge coinciding with the start of the read data phase.
REQ-017 Memory contents SHALL NOT be initialised or cleared by reset; readback before any write is don't-care.
REQ-018 hburst SHALL NOT affect behaviour; SEQ SHALL be handled identically to NONSEQ.
REQ-019 The block SHALL respond only in its own data phase; hreadyout SHALL be 1 whenever no data phase is pending.

Reset
REQ-020 While hreset=1 on a rising edge:
- state goes to IDLE and the wait counter is cleared;
- hreadyout=1, hresp=0, hrdata=0;
- no memory write occurs;
- a pending data phase is abandoned.
REQ-021 The first address phase accepted after hreset deasserts SHALL be processed normally.

Verification
REQ-022 WAIT_CYCLES=0: word write 0x0000_0010 data 0xDEAD_BEEF, then read 0x10 -> read data phase hrdata=0xDEADBEEF, hreadyout=1, hresp=0, no stall.
REQ-023 WAIT_CYCLES=2: read 0x10 -> hreadyout=0 for 2 cycles, then 1 with hrdata=0xDEADBEEF.
REQ-024 Byte write 0x13, hwdata=0xAA00_0000, hwstrb=4'hF, over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-025 Write to 0x100 (MEM_DEPTH=64) and word access at 0x02 -> each gives hreadyout 0 then 1 with hresp=1 both cycles; memory unchanged.
REQ-026 Back-to-back:
- Stimulus: NONSEQ write 0x20 = 0x12345678 immediately followed by a read of 0x20.
- Required response: read returns 0x12345678.
REQ-027 Reset mid-WAIT (WAIT_CYCLES=3, hreset in the 2nd wait cycle) -> next cycle hreadyout=1, hresp=0, hrdata=0; the following write/read completes normally.
